// File: rtl/ftdi_tx_writer_if.sv
// FIFO-side and FTDI-pin signals of the FT232H synchronous 245-FIFO transmit path.
// master: the writer; slave: the source FIFO / pins / testbench.
interface ftdi_tx_writer_if;
  logic        fifo_empty;
  logic [15:0] fifo_q;
  logic        fifo_rdreq;
  logic        ftxe_n;
  logic        fwr_n;
  logic [7:0]  fd_out;
  logic        fd_oe;
  logic        fsiwu_n;

  modport master (
    input  fifo_empty, fifo_q, ftxe_n,
    output fifo_rdreq, fwr_n, fd_out, fd_oe, fsiwu_n
  );

  modport slave (
    output fifo_empty, fifo_q, ftxe_n,
    input  fifo_rdreq, fwr_n, fd_out, fd_oe, fsiwu_n
  );
endinterface

// File: rtl/ftdi_tx_writer.sv
// FT232H 245-FIFO transmit: drains 16-bit words from the SDRAM readback FIFO as bytes on FU_D.
// Optional send-immediate (SIWU#) pulse after idle is built only with `define FTDI_TX_SIWU_EN.
module ftdi_tx_writer #(
  parameter bit          LSB_FIRST = 1'b1,
  parameter int unsigned SIWU_IDLE = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  ftdi_tx_writer_if.master    bus,
  output logic                busy,
  output logic [31:0]         bytes_sent
);

  logic [15:0] cur_q, cur_d, nxt_q, nxt_d;
  logic        cur_valid_q, cur_valid_d;
  logic        nxt_valid_q, nxt_valid_d;
  logic        bidx_q, bidx_d;
  logic        rd_inflight_q;
  logic        fwr_n_q, fwr_n_d;
  logic [7:0]  fd_out_q, fd_out_d;
  logic [31:0] bytes_sent_q, bytes_sent_d;
  logic        rdreq, accept, emptying;

  // A read is only issued when nxt is free and nothing is in flight, so the returning word
  // always has a slot. Gated by rst so the strobe is quiet while held in reset.
  assign rdreq    = ~rst & enable & ~bus.fifo_empty & ~rd_inflight_q & ~nxt_valid_q;
  assign accept   = ~fwr_n_q & ~bus.ftxe_n & cur_valid_q;
  assign emptying = accept & bidx_q;

  always_comb begin
    cur_d        = cur_q;
    cur_valid_d  = cur_valid_q;
    nxt_d        = nxt_q;
    nxt_valid_d  = nxt_valid_q;
    bidx_d       = bidx_q;
    bytes_sent_d = bytes_sent_q;

    if (accept) begin
      bytes_sent_d = bytes_sent_q + 32'd1;
      bidx_d       = ~bidx_q;
    end

    if (emptying) begin
      if (nxt_valid_q) begin
        cur_d = nxt_q;
      end
      cur_valid_d = nxt_valid_q;
      nxt_valid_d = 1'b0;
    end

    if (rd_inflight_q) begin
      if (!cur_valid_d) begin
        cur_d       = bus.fifo_q;
        cur_valid_d = 1'b1;
        bidx_d      = 1'b0;
      end else begin
        nxt_d       = bus.fifo_q;
        nxt_valid_d = 1'b1;
      end
    end

    // Post-update occupancy, so WR# never strobes past the end of the last held word.
    fwr_n_d  = ~(cur_valid_d & ~bus.ftxe_n);
    fd_out_d = (bidx_d ^ ~LSB_FIRST) ? cur_d[15:8] : cur_d[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_q         <= '0;
      cur_valid_q   <= 1'b0;
      nxt_q         <= '0;
      nxt_valid_q   <= 1'b0;
      bidx_q        <= 1'b0;
      rd_inflight_q <= 1'b0;
      fwr_n_q       <= 1'b1;
      fd_out_q      <= '0;
      bytes_sent_q  <= '0;
    end else begin
      cur_q         <= cur_d;
      cur_valid_q   <= cur_valid_d;
      nxt_q         <= nxt_d;
      nxt_valid_q   <= nxt_valid_d;
      bidx_q        <= bidx_d;
      rd_inflight_q <= rdreq;
      fwr_n_q       <= fwr_n_d;
      fd_out_q      <= fd_out_d;
      bytes_sent_q  <= bytes_sent_d;
    end
  end

  assign bus.fifo_rdreq = rdreq;
  assign bus.fwr_n      = fwr_n_q;
  assign bus.fd_out     = fd_out_q;
  assign bus.fd_oe      = cur_valid_q;
  assign busy           = cur_valid_q | nxt_valid_q | rd_inflight_q;
  assign bytes_sent     = bytes_sent_q;

`ifdef FTDI_TX_SIWU_EN
  localparam int unsigned IdleW = $clog2(SIWU_IDLE + 1);

  logic [IdleW-1:0] idle_cnt_q;
  logic             armed_q;
  logic             fsiwu_n_q;

  // Armed by any accepted byte; one SIWU# pulse after SIWU_IDLE consecutive idle cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt_q <= '0;
      armed_q    <= 1'b0;
      fsiwu_n_q  <= 1'b1;
    end else begin
      fsiwu_n_q <= 1'b1;
      if (accept) begin
        armed_q    <= 1'b1;
        idle_cnt_q <= '0;
      end else if (busy) begin
        idle_cnt_q <= '0;
      end else if (armed_q) begin
        if (idle_cnt_q == IdleW'(SIWU_IDLE - 1)) begin
          fsiwu_n_q  <= 1'b0;
          armed_q    <= 1'b0;
          idle_cnt_q <= '0;
        end else begin
          idle_cnt_q <= idle_cnt_q + 1'b1;
        end
      end
    end
  end

  assign bus.fsiwu_n = fsiwu_n_q;
`else
  // SIWU_IDLE only sizes the idle counter, which is not built here.
  assign bus.fsiwu_n = 1'b1 | (SIWU_IDLE == 0);
`endif

endmodule

// File: tb/tb_ftdi_tx_writer.sv
// Self-checking bench for ftdi_tx_writer: FIFO model, byte-stream reference model, LSB/MSB DUTs.
module tb_ftdi_tx_writer;
  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        busy, busy_m;
  logic [31:0] bytes_sent, bytes_sent_m;

  ftdi_tx_writer_if tx ();
  ftdi_tx_writer_if txm ();

  always #5 clk = ~clk;

  ftdi_tx_writer #(.LSB_FIRST(1'b1), .SIWU_IDLE(16)) dut (
    .clk(clk), .rst(rst), .enable(enable), .bus(tx.master), .busy(busy), .bytes_sent(bytes_sent)
  );
  ftdi_tx_writer #(.LSB_FIRST(1'b0), .SIWU_IDLE(16)) dut_msb (
    .clk(clk), .rst(rst), .enable(enable), .bus(txm.master), .busy(busy_m),
    .bytes_sent(bytes_sent_m)
  );

  logic [15:0] fifo_mem[$];
  int          fifo_cnt = 0;
  bq_t         exp_lsb, exp_msb, acc_lsb, acc_msb;
  int          acc_cyc[$], rd_cyc[$], siwu_cyc[$];
  int          cyc = 0, rd_cnt = 0, bogus = 0, busy_fall = -1;
  int          n_chk = 0, n_pass = 0;
  logic        rdreq_s = 1'b0, fwr_s = 1'b1, ftxe_s = 1'b1, oe_s = 1'b0, fwr_m_s = 1'b1;
  logic        busy_s = 1'b0, busy_prev = 1'b0, siwu_s = 1'b1;
  logic [7:0]  fd_s = '0, fd_m_s = '0;

  assign tx.fifo_empty  = (fifo_cnt == 0);
  assign txm.fifo_empty = tx.fifo_empty;
  assign txm.fifo_q     = tx.fifo_q;
  assign txm.ftxe_n     = tx.ftxe_n;

  // Inputs change at negedge; snapshot everything once it has settled for the next posedge.
  always @(negedge clk) begin
    fifo_cnt = fifo_mem.size();
    #1;
    rdreq_s = tx.fifo_rdreq;  fwr_s = tx.fwr_n;  ftxe_s = tx.ftxe_n;  fd_s = tx.fd_out;
    oe_s = tx.fd_oe;  fwr_m_s = txm.fwr_n;  fd_m_s = txm.fd_out;  busy_s = busy;
    siwu_s = tx.fsiwu_n;
  end

  // FIFO read port (one-cycle latency) and bus monitor.
  always @(posedge clk) begin
    cyc++;
    if (rdreq_s) begin
      rd_cnt++;
      rd_cyc.push_back(cyc);
      if (fifo_mem.size() > 0) tx.fifo_q <= fifo_mem.pop_front();
    end
    if (!fwr_s && !ftxe_s) begin
      acc_lsb.push_back(fd_s);
      acc_cyc.push_back(cyc);
      if (!oe_s) bogus++;
    end
    if (!fwr_m_s && !ftxe_s) acc_msb.push_back(fd_m_s);
    if (!siwu_s) siwu_cyc.push_back(cyc);
    if (busy_prev && !busy_s) busy_fall = cyc;
    busy_prev = busy_s;
  end

  function automatic int seq_diff(input bq_t a, input bq_t b);
    int d = (a.size() > b.size()) ? a.size() - b.size() : b.size() - a.size();
    for (int i = 0; i < a.size() && i < b.size(); i++) if (a[i] !== b[i]) d++;
    return d;
  endfunction

  // Reference model: every word read from the FIFO reaches the bus whole, in FIFO order.
  task automatic push_word(input logic [15:0] w);
    fifo_mem.push_back(w);
    exp_lsb.push_back(w[7:0]);  exp_lsb.push_back(w[15:8]);
    exp_msb.push_back(w[15:8]); exp_msb.push_back(w[7:0]);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1; enable = 1'b0; tx.ftxe_n = 1'b1;
    fifo_mem.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_lsb.delete(); exp_msb.delete(); acc_lsb.delete(); acc_msb.delete();
    acc_cyc.delete(); rd_cyc.delete(); siwu_cyc.delete();
    rd_cnt = 0; bogus = 0; busy_fall = -1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    enable = 1'b1; tx.ftxe_n = 1'b0;
    fifo_mem.push_back(16'h1111);
    repeat (3) @(negedge clk);
    #2;
    n_chk++;
    if ({tx.fifo_rdreq, tx.fwr_n, tx.fd_out, tx.fd_oe, tx.fsiwu_n, busy} !== 13'b0_1_00000000_0_1_0)
      $display("FAIL reset_ctrl: got %b want 0100000000010",
               {tx.fifo_rdreq, tx.fwr_n, tx.fd_out, tx.fd_oe, tx.fsiwu_n, busy});
    else n_pass++;
    n_chk++;
    if (bytes_sent !== 32'd0) $display("FAIL reset_count: got %0h want 0", bytes_sent);
    else n_pass++;
  endtask

  task automatic test_basic();
    int lat, span;
    reset_dut();
    push_word(16'h1234); push_word(16'hABCD);
    @(negedge clk);
    enable = 1'b1; tx.ftxe_n = 1'b0;
    for (int i = 0; i < 40 && acc_lsb.size() < 4; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    lat  = (acc_cyc.size() > 0 && rd_cyc.size() > 0) ? acc_cyc[0] - rd_cyc[0] : -1;
    span = (acc_cyc.size() >= 4) ? acc_cyc[3] - acc_cyc[0] : -1;
    n_chk++;
    if (seq_diff(acc_lsb, exp_lsb) != 0)
      $display("FAIL basic_lsb_bytes: got %p want %p", acc_lsb, exp_lsb);
    else n_pass++;
    n_chk++;
    if (seq_diff(acc_msb, exp_msb) != 0)
      $display("FAIL basic_msb_bytes: got %p want %p", acc_msb, exp_msb);
    else n_pass++;
    n_chk++;
    if (bytes_sent !== 32'd4) $display("FAIL basic_count: got %0d want 4", bytes_sent);
    else n_pass++;
    n_chk++;
    if (busy !== 1'b0) $display("FAIL basic_busy_idle: got %b want 0", busy);
    else n_pass++;
    n_chk++;
    if (rd_cnt != 2) $display("FAIL basic_rdreq_pulses: got %0d want 2", rd_cnt);
    else n_pass++;
    n_chk++;
    if (span != 3) $display("FAIL basic_consecutive: got span %0d want 3", span);
    else n_pass++;
    // rdreq cycle, data cycle, write cycle, then the accepting edge.
    n_chk++;
    if (lat != 2) $display("FAIL basic_latency: got %0d edges want 2", lat);
    else n_pass++;
  endtask

  task automatic test_throughput();
    int max_gap = 0;
    reset_dut();
    for (int w = 1; w <= 256; w++) push_word(16'(w));
    @(negedge clk);
    enable = 1'b1; tx.ftxe_n = 1'b0;
    for (int i = 0; i < 700 && acc_lsb.size() < 512; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    for (int i = 1; i < acc_cyc.size(); i++)
      if (acc_cyc[i] - acc_cyc[i-1] > max_gap) max_gap = acc_cyc[i] - acc_cyc[i-1];
    n_chk++;
    if (acc_lsb.size() != 512) $display("FAIL tput_len: got %0d want 512", acc_lsb.size());
    else n_pass++;
    n_chk++;
    if (seq_diff(acc_lsb, exp_lsb) != 0)
      $display("FAIL tput_bytes: got %0d mismatches want 0", seq_diff(acc_lsb, exp_lsb));
    else n_pass++;
    n_chk++;
    if (max_gap != 1) $display("FAIL tput_gap: got %0d want 1", max_gap);
    else n_pass++;
    n_chk++;
    if (bytes_sent !== 32'd512) $display("FAIL tput_count: got %0d want 512", bytes_sent);
    else n_pass++;
    n_chk++;
    if (rd_cnt != 256) $display("FAIL tput_rdreq: got %0d want 256", rd_cnt);
    else n_pass++;
  endtask

  task automatic test_ftxe_hold();
    reset_dut();
    push_word(16'h1234);
    @(negedge clk);
    enable = 1'b1; tx.ftxe_n = 1'b0;
    for (int i = 0; i < 20 && tx.fwr_n !== 1'b0; i++) @(negedge clk);
    tx.ftxe_n = 1'b1;
    repeat (5) @(negedge clk);
    n_chk++;
    if (bytes_sent !== 32'd0) $display("FAIL hold_no_accept: got %0d want 0", bytes_sent);
    else n_pass++;
    n_chk++;
    if ({tx.fwr_n, tx.fd_out, tx.fd_oe} !== {1'b1, 8'h34, 1'b1})
      $display("FAIL hold_state: got %b %h %b want 1 34 1", tx.fwr_n, tx.fd_out, tx.fd_oe);
    else n_pass++;
    tx.ftxe_n = 1'b0;
    for (int i = 0; i < 20 && acc_lsb.size() < 2; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    n_chk++;
    if (seq_diff(acc_lsb, exp_lsb) != 0)
      $display("FAIL hold_bytes: got %p want %p", acc_lsb, exp_lsb);
    else n_pass++;
    n_chk++;
    if (bytes_sent !== 32'd2) $display("FAIL hold_count: got %0d want 2", bytes_sent);
    else n_pass++;
  endtask

  task automatic test_enable_drop_reset();
    reset_dut();
    push_word(16'h5678); push_word(16'h0009);
    fifo_mem.push_back(16'h1111); fifo_mem.push_back(16'h2222);
    @(negedge clk);
    enable = 1'b1; tx.ftxe_n = 1'b0;
    for (int i = 0; i < 20 && acc_lsb.size() < 1; i++) @(negedge clk);
    enable = 1'b0;
    for (int i = 0; i < 30 && acc_lsb.size() < 4; i++) @(negedge clk);
    repeat (20) @(negedge clk);
    n_chk++;
    if (seq_diff(acc_lsb, exp_lsb) != 0)
      $display("FAIL drop_bytes: got %p want %p", acc_lsb, exp_lsb);
    else n_pass++;
    n_chk++;
    if (rd_cnt != 2 || fifo_mem.size() != 2)
      $display("FAIL drop_rdreq: got %0d reads, %0d left want 2, 2", rd_cnt, fifo_mem.size());
    else n_pass++;
    n_chk++;
    if ({busy, bytes_sent} !== {1'b0, 32'd4})
      $display("FAIL drop_final: got busy %b count %0d want 0 4", busy, bytes_sent);
    else n_pass++;
    // Resume, then reset in the middle of 0x1111.
    enable = 1'b1;
    for (int i = 0; i < 30 && bytes_sent !== 32'd5; i++) @(negedge clk);
    rst = 1'b1;
    #1;
    n_chk++;
    if ({tx.fifo_rdreq, tx.fwr_n, tx.fd_out, tx.fd_oe, tx.fsiwu_n, busy, bytes_sent} !==
        {1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 32'd0})
      $display("FAIL midword_reset: got rdreq %b wr %b d %h oe %b siwu %b busy %b cnt %0d",
               tx.fifo_rdreq, tx.fwr_n, tx.fd_out, tx.fd_oe, tx.fsiwu_n, busy, bytes_sent);
    else n_pass++;
    fifo_mem.delete(); exp_lsb.delete(); exp_msb.delete(); acc_lsb.delete(); acc_msb.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    push_word(16'hBEEF);
    for (int i = 0; i < 20 && acc_lsb.size() < 2; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    n_chk++;
    if (seq_diff(acc_lsb, exp_lsb) != 0 || bytes_sent !== 32'd2)
      $display("FAIL fresh_word: got %p cnt %0d want %p cnt 2", acc_lsb, bytes_sent, exp_lsb);
    else n_pass++;
  endtask

  task automatic test_random();
    int pushed = 0;
    localparam int N = 24;
    reset_dut();
    enable = 1'b1;
    for (int i = 0; i < 4000 && !(pushed == N && acc_lsb.size() == 2 * N); i++) begin
      @(negedge clk);
      tx.ftxe_n = ($urandom_range(0, 2) == 0);
      enable    = ($urandom_range(0, 7) != 0);
      if (pushed < N && $urandom_range(0, 3) == 0) begin
        push_word(16'($urandom));
        pushed++;
      end
    end
    enable = 1'b1; tx.ftxe_n = 1'b0;
    repeat (10) @(negedge clk);
    n_chk++;
    if (seq_diff(acc_lsb, exp_lsb) != 0)
      $display("FAIL rand_lsb: got %0d mismatches, len %0d want 0, %0d",
               seq_diff(acc_lsb, exp_lsb), acc_lsb.size(), exp_lsb.size());
    else n_pass++;
    n_chk++;
    if (seq_diff(acc_msb, exp_msb) != 0)
      $display("FAIL rand_msb: got %0d mismatches want 0", seq_diff(acc_msb, exp_msb));
    else n_pass++;
    n_chk++;
    if (bytes_sent !== 32'(2 * N)) $display("FAIL rand_count: got %0d want %0d", bytes_sent, 2 * N);
    else n_pass++;
    n_chk++;
    if (bogus != 0 || busy !== 1'b0)
      $display("FAIL rand_protocol: got %0d strobes without data, busy %b want 0, 0", bogus, busy);
    else n_pass++;
  endtask

  task automatic test_siwu();
    reset_dut();
    push_word(16'h4242);
    @(negedge clk);
    enable = 1'b1; tx.ftxe_n = 1'b0;
    for (int i = 0; i < 20 && acc_lsb.size() < 2; i++) @(negedge clk);
    repeat (80) @(negedge clk);
`ifdef FTDI_TX_SIWU_EN
    n_chk++;
    if (siwu_cyc.size() != 1) $display("FAIL siwu_pulses: got %0d want 1", siwu_cyc.size());
    else n_pass++;
    n_chk++;
    if (siwu_cyc.size() < 1 || siwu_cyc[0] - busy_fall != 16)
      $display("FAIL siwu_delay: got %0d want 16",
               (siwu_cyc.size() > 0) ? siwu_cyc[0] - busy_fall : -1);
    else n_pass++;
`else
    n_chk++;
    if (siwu_cyc.size() != 0) $display("FAIL siwu_tied: got %0d pulses want 0", siwu_cyc.size());
    else n_pass++;
`endif
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; tx.ftxe_n = 1'b1;
    test_reset();
    test_basic();
    test_throughput();
    test_ftxe_hold();
    test_enable_drop_reset();
    test_random();
    test_siwu();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish by 1000000 want finish");
    $fatal(1, "watchdog");
  end
endmodule
